// File: rtl/hpi_bus_sequencer.sv
// HPI bus cycle engine: arbitrates m0/m1, then runs one timed HPI access.
// Define HPI_RR_ARB_EN for round-robin arbitration (default: m0 over m1).
module hpi_bus_sequencer #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic        hpi_cs_n,
  output logic        hpi_rd_n,
  output logic        hpi_wr_n,
  output logic [1:0]  hpi_addr,
  output logic [15:0] hpi_dout,
  output logic        hpi_dout_oe,
  input  logic [15:0] hpi_din,
  output logic        busy
);

  localparam logic [3:0] LD_SETUP   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] LD_STROBE  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] LD_HOLD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] LD_RECOVER = 4'(RECOVER_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic        r_id;
  logic        r_we;
  logic [1:0]  r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_m0_rdata;
  logic [15:0] r_m1_rdata;

  logic        w_any_req;
  logic        w_grant;
  logic        w_win;
  logic        w_cs_n;
  logic        w_rd_n;
  logic        w_wr_n;
  logic        w_oe;
  logic        w_drive_addr;
  logic        w_ack;
  logic        w_capture;

  assign w_any_req = m0_req | m1_req;
  assign w_grant   = (r_state == S_IDLE) & w_any_req;

`ifdef HPI_RR_ARB_EN
  // r_ptr names the master preferred on the next tie (1 = m1)
  logic r_ptr;

  assign w_win = (m0_req & m1_req) ? r_ptr : ~m0_req;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_ptr <= 1'b0;
    end else if (w_grant) begin
      r_ptr <= ~w_win;
    end
  end
`else
  assign w_win = ~m0_req;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 2'd0;
      r_wdata <= 16'd0;
    end else if (w_grant) begin
      r_id    <= w_win;
      r_we    <= w_win ? m1_we    : m0_we;
      r_addr  <= w_win ? m1_addr  : m0_addr;
      r_wdata <= w_win ? m1_wdata : m0_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = LD_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = LD_STROBE;
        end
      end
      S_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = LD_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RECOVER;
          w_cnt_nxt   = LD_RECOVER;
        end
      end
      S_RECOVER: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_cs_n       = 1'b1;
    w_rd_n       = 1'b1;
    w_wr_n       = 1'b1;
    w_oe         = 1'b0;
    w_drive_addr = 1'b0;
    unique case (r_state)
      S_SETUP, S_HOLD: begin
        w_cs_n       = 1'b0;
        w_oe         = r_we;
        w_drive_addr = 1'b1;
      end
      S_STROBE: begin
        w_cs_n       = 1'b0;
        w_rd_n       = r_we;
        w_wr_n       = ~r_we;
        w_oe         = r_we;
        w_drive_addr = 1'b1;
      end
      default: begin
        w_cs_n = 1'b1;
      end
    endcase
  end

  // counter holds its load value only in the first RECOVER cycle
  assign w_ack     = (r_state == S_RECOVER) & (r_cnt == LD_RECOVER);
  assign w_capture = (r_state == S_STROBE) & (r_cnt == 4'd0) & ~r_we;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_m0_rdata <= 16'd0;
      r_m1_rdata <= 16'd0;
    end else if (w_capture) begin
      if (r_id) r_m1_rdata <= hpi_din;
      else      r_m0_rdata <= hpi_din;
    end
  end

  assign hpi_cs_n    = w_cs_n;
  assign hpi_rd_n    = w_rd_n;
  assign hpi_wr_n    = w_wr_n;
  assign hpi_dout_oe = w_oe;
  assign hpi_addr    = w_drive_addr ? r_addr : 2'd0;
  assign hpi_dout    = w_oe ? r_wdata : 16'd0;
  assign busy        = (r_state != S_IDLE);
  assign m0_ack      = w_ack & ~r_id;
  assign m1_ack      = w_ack & r_id;
  assign m0_rdata    = r_m0_rdata;
  assign m1_rdata    = r_m1_rdata;

endmodule
